counter: RTL and testbench

Loadable 32-bit down-counter with a two-state control FSM, used as the basic timed-countdown block in FSM demo designs. A one-cycle `start` pulse loads `cnt_init`. The block then decrements once per clock until it reaches zero and returns to idle. `ready` flags when a new `start` will be accepted.

---
 rtl/counter_if.sv | 24 ++
 rtl/counter.sv | 65 ++++++
 tb/tb_counter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/counter_if.sv
// counter_if: control/status bundle of the countdown block.
// cnt_init/start go in, cnt/ready come back out.
interface counter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] cnt_init;
  logic             start;
  logic [WIDTH-1:0] cnt;
  logic             ready;

  modport master (
    output cnt_init,
    output start,
    input  cnt,
    input  ready
  );

  modport slave (
    input  cnt_init,
    input  start,
    output cnt,
    output ready
  );
endinterface

// File: rtl/counter.sv
// counter: loadable down-counter with IDLE/COUNT control FSM.
// Ports: clk, rst (sync, active-high), bus (counter_if.slave).
module counter #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  counter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // A zero load completes instantly and never enters COUNT.
          if (bus.cnt_init != '0) begin
            cnt_d   = bus.cnt_init;
            state_d = COUNT;
          end else begin
            cnt_d = '0;
          end
        end
      end
      COUNT: begin
        // <=1 rather than ==1 so the count can never wrap.
        if (cnt_q <= WIDTH'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cnt   = cnt_q;
  assign bus.ready = (state_q == IDLE);

endmodule

// File: tb/tb_counter.sv
// tb_counter: vector table plus hand sequences for counter.
// Expected outputs queued at drive time, popped after each edge.
module tb_counter;

  typedef struct {
    logic        rst;
    logic        start;
    logic [31:0] init;
    logic [31:0] cnt;
    logic        rdy;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] cnt;
    logic        rdy;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  vec_t vecs[$];

  counter_if #(.WIDTH(32)) bus ();

  counter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic step(
    input logic        r,
    input logic        s,
    input logic [31:0] init,
    input logic [31:0] ecnt,
    input logic        erdy,
    input string       name
  );
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst          = r;
    bus.start    = s;
    bus.cnt_init = init;
    e.cnt  = ecnt;
    e.rdy  = erdy;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    n_cmp++;
    if (bus.cnt !== g.cnt || bus.ready !== g.rdy) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0h ready=%b, want cnt=%0h ready=%b",
               g.name, bus.cnt, bus.ready, g.cnt, g.rdy);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.cnt_init = '0;
    n_cmp        = 0;
    n_bad        = 0;

    vecs.push_back('{1'b1, 1'b0, 32'd0, 32'd0, 1'b1, "reset1"});
    vecs.push_back('{1'b1, 1'b0, 32'd0, 32'd0, 1'b1, "reset2"});
    vecs.push_back('{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "idle1"});
    vecs.push_back('{1'b0, 1'b0, 32'd7, 32'd0, 1'b1, "idle2"});
    vecs.push_back('{1'b0, 1'b1, 32'd0, 32'd0, 1'b1, "zero1"});
    vecs.push_back('{1'b0, 1'b1, 32'd0, 32'd0, 1'b1, "zero2"});
    vecs.push_back('{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "zero3"});
    vecs.push_back('{1'b0, 1'b1, 32'd5, 32'd5, 1'b0, "ign5"});
    vecs.push_back('{1'b0, 1'b0, 32'd0, 32'd4, 1'b0, "ign4"});
    vecs.push_back('{1'b0, 1'b0, 32'd0, 32'd3, 1'b0, "ign3"});
    vecs.push_back('{1'b0, 1'b1, 32'd100, 32'd2, 1'b0, "ign2"});
    vecs.push_back('{1'b0, 1'b0, 32'd0, 32'd1, 1'b0, "ign1"});
    vecs.push_back('{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "ign0"});
    vecs.push_back('{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "ignhold"});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     1'b0, "max0"});
    vecs.push_back('{1'b0, 1'b0, 32'd0, 32'hFFFF_FFFE, 1'b0, "max1"});
    vecs.push_back('{1'b0, 1'b0, 32'd0, 32'hFFFF_FFFD, 1'b0, "max2"});
    vecs.push_back('{1'b1, 1'b1, 32'd9, 32'd0, 1'b1, "maxrst"});
    vecs.push_back('{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "postrst"});

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].start, vecs[i].init,
           vecs[i].cnt, vecs[i].rdy, vecs[i].name);

    // basic count of 10
    step(1'b0, 1'b1, 32'd10, 32'd10, 1'b0, "basic_load");
    for (int k = 9; k >= 1; k--)
      step(1'b0, 1'b0, 32'd0, 32'(k), 1'b0, "basic_dec");
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "basic_zero");
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "basic_hold");

    // back-to-back with start held
    for (int r = 0; r < 3; r++) begin
      step(1'b0, 1'b1, 32'd2, 32'd2, 1'b0, "b2b_2");
      step(1'b0, 1'b1, 32'd2, 32'd1, 1'b0, "b2b_1");
      step(1'b0, 1'b1, 32'd2, 32'd0, 1'b1, "b2b_0");
    end
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "b2b_end");

    // reset mid-count
    step(1'b0, 1'b1, 32'd20, 32'd20, 1'b0, "mid_load");
    for (int k = 19; k >= 12; k--)
      step(1'b0, 1'b0, 32'd0, 32'(k), 1'b0, "mid_dec");
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, "mid_rst");
    step(1'b0, 1'b1, 32'd4, 32'd4, 1'b0, "mid_reload");
    for (int k = 3; k >= 1; k--)
      step(1'b0, 1'b0, 32'd0, 32'(k), 1'b0, "mid_redec");
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "mid_rezero");

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
